// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches, buffers responses in a small FIFO,
// presents them to decode and discards stale responses after a redirect.
module fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    typedef enum logic {StRun, StDrain} state_e;

    state_e        r_state;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_stale;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_aq_wr;
    logic [PW-1:0] r_aq_rd;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [31:0]   r_aq         [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];

    logic          w_req_valid;
    logic          w_fire;
    logic          w_rsp_take;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_if_valid;
    logic          w_pop;
    logic [CW-1:0] w_out_after;

    // Responses with nothing outstanding are protocol errors and are ignored entirely.
    assign w_rsp_take  = imem_rsp_valid & (r_outstanding != '0);
    assign w_rsp_drop  = (r_stale != '0) | redirect_valid;
    assign w_push      = w_rsp_take & ~w_rsp_drop;
    assign w_out_after = r_outstanding - CW'(w_rsp_take);

    // Reserving a FIFO slot per outstanding request means a response never finds the FIFO full.
    assign w_req_valid = ~reset & (r_state == StRun) & ~redirect_valid &
                         (({1'b0, r_count} + {1'b0, r_outstanding}) < DepthW);
    assign w_fire      = w_req_valid & imem_req_ready;
    assign w_if_valid  = (r_count != '0) & ~redirect_valid;
    assign w_pop       = w_if_valid & if_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = pc_q;
    assign if_valid       = w_if_valid;
    assign if_pc          = r_fifo_pc[r_rd];
    assign if_instr       = r_fifo_instr[r_rd];

    always_comb begin
        pc_next = pc_q;
        if (!reset) begin
            if (redirect_valid) begin
                pc_next = redirect_pc & 32'hFFFF_FFFC;
            end else if (w_fire) begin
                pc_next = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_aq[i] <= '0;
            end
        end else begin
            if (w_fire) begin
                r_aq[r_aq_wr] <= pc_q;
                r_aq_wr       <= r_aq_wr + PW'(1);
            end
            if (w_rsp_take) begin
                r_aq_rd <= r_aq_rd + PW'(1);
            end
            r_outstanding <= w_out_after + CW'(w_fire);
        end
    end

    // In DRAIN nothing issues, so every outstanding request is stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
            r_stale <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (redirect_valid && (w_out_after != '0)) begin
                        r_state <= StDrain;
                        r_stale <= w_out_after;
                    end
                end
                StDrain: begin
                    if (w_rsp_take) begin
                        r_stale <= r_stale - CW'(1);
                        if (r_stale == CW'(1)) begin
                            r_state <= StRun;
                        end
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_stale <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr]    <= r_aq[r_aq_rd];
                r_fifo_instr[r_wr] <= imem_rsp_data;
                r_wr               <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side PC register and memory, queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_q           (pc_q),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_next;
    end

    typedef struct {logic [31:0] addr; bit stale;} out_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    out_t  m_out[$];
    ent_t  m_fifo[$];
    mreq_t mem_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cycle = 0;
    int last_due = 0;

    bit          k_req_ready, k_if_ready, k_redir, k_spur;
    logic [31:0] k_rpc;
    int          k_lat_min = 1, k_lat_max = 1;

    logic        obs_req_valid, obs_if_valid;
    logic [31:0] obs_req_addr, obs_pc_next, obs_if_pc, obs_if_instr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5C3_0F96 ^ {a[15:0], a[31:16]} ^ (a * 32'd2654435761);
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, got, exp);
        end
    endtask

    // Reference: FIFO and in-flight requests as queues; in-flight entries carry a stale flag.
    task automatic model_cycle();
        bit draining = 0;
        bit e_req, e_fire, e_ifv, push = 0;
        logic [31:0] e_pcn;
        out_t o;
        ent_t e;
        foreach (m_out[i]) if (m_out[i].stale) draining = 1;
        e_req  = !redirect_valid && !draining && (m_fifo.size() + m_out.size() < DEPTH);
        e_fire = e_req && imem_req_ready;
        e_ifv  = (m_fifo.size() > 0) && !redirect_valid;
        if (redirect_valid) e_pcn = {redirect_pc[31:2], 2'b00};
        else if (e_fire)    e_pcn = pc_q + 32'd4;
        else                e_pcn = pc_q;

        cmp("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) cmp("req_addr", imem_req_addr, pc_q);
        cmp("pc_next", pc_next, e_pcn);
        cmp("if_valid", 32'(if_valid), 32'(e_ifv));
        if (e_ifv) begin
            cmp("if_pc", if_pc, m_fifo[0].pc);
            cmp("if_instr", if_instr, m_fifo[0].instr);
        end

        if (imem_rsp_valid && m_out.size() > 0) begin
            o = m_out.pop_front();
            push = !o.stale && !redirect_valid;
            e.pc = o.addr;
            e.instr = mem_data(o.addr);
        end
        if (redirect_valid) begin
            m_fifo.delete();
            foreach (m_out[i]) m_out[i].stale = 1;
        end else begin
            if (e_ifv && if_ready) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(e);
        end
        if (e_fire) m_out.push_back('{pc_q, 1'b0});
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step();
        mreq_t m;
        int lat, due;
        imem_req_ready = k_req_ready;
        if_ready       = k_if_ready;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(m.addr);
        end else if (k_spur && mem_q.size() == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_pc_next   = pc_next;
        obs_if_valid  = if_valid;
        obs_if_pc     = if_pc;
        obs_if_instr  = if_instr;
        model_cycle();
        if (imem_req_valid && imem_req_ready) begin
            lat = k_lat_min + int'($urandom % 32'(k_lat_max - k_lat_min + 1));
            due = cycle + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{imem_req_addr, due});
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset(input bit chk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        m_out.delete();
        m_fifo.delete();
        mem_q.delete();
        @(negedge clk);
        if (chk) begin
            cmp("rst_if_valid", 32'(if_valid), 32'd0);
            cmp("rst_req_valid", 32'(imem_req_valid), 32'd0);
            cmp("rst_pc_next", pc_next, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle++;
        last_due = cycle;
    endtask

    task automatic knobs(input bit rr, input bit ir, input int lmin, input int lmax);
        k_req_ready = rr;
        k_if_ready  = ir;
        k_lat_min   = lmin;
        k_lat_max   = lmax;
        k_redir     = 1'b0;
        k_rpc       = '0;
        k_spur      = 1'b0;
    endtask

    task automatic wait_if_valid(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 12 && !obs_if_valid; i++) step();
        cmp({name, "_seen"}, 32'(obs_if_valid), 32'd1);
        cmp({name, "_pc"}, obs_if_pc, exp_pc);
    endtask

    initial begin
        #1;
        // Streaming, 1-cycle memory, decode always ready.
        knobs(1, 1, 1, 1);
        do_reset(1);
        step();
        cmp("t1_req0_valid", 32'(obs_req_valid), 32'd1);
        cmp("t1_req0_addr", obs_req_addr, 32'h0);
        step();
        cmp("t1_req1_addr", obs_req_addr, 32'h4);
        cmp("t1_if_valid_c1", 32'(obs_if_valid), 32'd0);
        step();
        cmp("t1_if_pc0", obs_if_pc, 32'h0);
        cmp("t1_if_instr0", obs_if_instr, mem_data(32'h0));
        step();
        cmp("t1_req2_addr", obs_req_addr, 32'h8);
        cmp("t1_if_pc1", obs_if_pc, 32'h4);

        // Decode stalled: FIFO fills, fetch stops, then drains in order.
        knobs(1, 0, 1, 1);
        do_reset(0);
        repeat (4) step();
        cmp("t2_req_stopped", 32'(obs_req_valid), 32'd0);
        cmp("t2_pc_hold", obs_pc_next, 32'h8);
        repeat (2) step();
        k_if_ready = 1'b1;
        step();
        cmp("t2_first_pc", obs_if_pc, 32'h0);
        step();
        cmp("t2_second_pc", obs_if_pc, 32'h4);
        cmp("t2_resume_addr", obs_req_addr, 32'h8);

        // Redirect with two requests outstanding.
        knobs(1, 1, 4, 4);
        do_reset(0);
        repeat (3) step();
        k_redir = 1'b1;
        k_rpc   = 32'h103;
        step();
        cmp("t3_pc_next", obs_pc_next, 32'h100);
        cmp("t3_if_valid", 32'(obs_if_valid), 32'd0);
        k_redir = 1'b0;
        for (int i = 0; i < 10 && mem_q.size() > 0; i++) begin
            step();
            cmp("t3_no_req_drain", 32'(obs_req_valid), 32'd0);
        end
        step();
        cmp("t3_restart_addr", obs_req_addr, 32'h100);
        wait_if_valid("t3_deliver", 32'h100);

        // Redirect coinciding with a response and a pending decode handshake.
        knobs(1, 1, 1, 1);
        do_reset(0);
        repeat (2) step();
        k_redir = 1'b1;
        k_rpc   = 32'h200;
        step();
        cmp("t4_if_valid", 32'(obs_if_valid), 32'd0);
        k_redir = 1'b0;
        step();
        wait_if_valid("t4_deliver", 32'h200);

        // PC wrap at the top of the address space.
        knobs(1, 1, 1, 1);
        do_reset(0);
        k_redir = 1'b1;
        k_rpc   = 32'hFFFF_FFFC;
        step();
        k_redir = 1'b0;
        step();
        cmp("t5_addr", obs_req_addr, 32'hFFFF_FFFC);
        cmp("t5_wrap", obs_pc_next, 32'h0);
        wait_if_valid("t5_deliver", 32'hFFFF_FFFC);

        // Reset with requests in flight, then with the FIFO full.
        knobs(1, 0, 4, 4);
        do_reset(0);
        repeat (3) step();
        do_reset(1);
        knobs(1, 0, 1, 1);
        step();
        cmp("t6_restart_addr", obs_req_addr, 32'h0);
        repeat (4) step();
        do_reset(1);

        knobs(1, 1, 1, 4);
        for (int i = 0; i < 4000; i++) begin
            k_req_ready = ($urandom % 4) != 0;
            k_if_ready  = ($urandom % 3) != 0;
            k_redir     = ($urandom % 12) == 0;
            k_rpc       = $urandom;
            k_spur      = ($urandom % 25) == 0;
            if (($urandom % 400) == 0) do_reset(1);
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
